// File: rtl/tft_lcd_pkg.sv
// Shared types for the TFT LCD transmitter: controller state encoding and the
// RGB888 pixel type, plus the counter width helper used by both modules.
package tft_lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } tft_state_e;

  typedef logic [23:0] rgb888_t;

  localparam rgb888_t RGB_BLACK = 24'h000000;

  function automatic int cnt_width(input int total);
    return (total > 1) ? $clog2(total) : 1;
  endfunction

endpackage

// File: rtl/tft_timing_cnt.sv
// Horizontal/vertical raster counters with region decode. Each line is ordered
// active, front porch, sync, back porch; the frame uses the same order in lines.
module tft_timing_cnt
  import tft_lcd_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29,
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW      = cnt_width(H_TOTAL),
  localparam int VW      = cnt_width(V_TOTAL)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          run_i,
  output logic [HW-1:0] hcnt_o,
  output logic [VW-1:0] vcnt_o,
  output logic          active_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_end_o
);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          h_last_s;

  // Next count: held at zero while stopped, vcnt advances on hcnt wrap.
  always_comb begin
    h_last_s = (hcnt_q == H_LAST);
    hcnt_d   = hcnt_q;
    vcnt_d   = vcnt_q;
    if (!run_i) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_last_s) begin
      hcnt_d = '0;
      if (vcnt_q == V_LAST) begin
        vcnt_d = '0;
      end else begin
        vcnt_d = vcnt_q + VW'(1);
      end
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  assign hcnt_o      = hcnt_q;
  assign vcnt_o      = vcnt_q;
  assign active_o    = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
  assign hsync_o     = (hcnt_q >= H_SYNC_S) && (hcnt_q < H_SYNC_E);
  assign vsync_o     = (vcnt_q >= V_SYNC_S) && (vcnt_q < V_SYNC_E);
  assign frame_end_o = h_last_s && (vcnt_q == V_LAST);

endmodule

// File: rtl/tft_lcd_tx.sv
// RGB888 parallel TFT transmitter: converts a valid/ready pixel stream with
// start-of-frame marking into DE/HSYNC/VSYNC panel timing.
module tft_lcd_tx
  import tft_lcd_pkg::*;
#(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 48,
  parameter int H_BP     = 40,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 13,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 29
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        PIX_VALID,
  output logic        PIX_READY,
  input  logic        PIX_SOF,
  input  logic [23:0] PIX_DATA,
  output logic        TFT_PCLK,
  output logic        TFT_DISP,
  output logic        TFT_HSYNC,
  output logic        TFT_VSYNC,
  output logic        TFT_DE,
  output logic [23:0] TFT_RGB,
  output logic        FRAME_DONE,
  output logic        UNDERFLOW,
  input  logic        UNDERFLOW_CLR
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = cnt_width(H_TOTAL);
  localparam int VW      = cnt_width(V_TOTAL);
  localparam logic [HW-1:0] H_LAST_ACT = HW'(H_ACTIVE - 1);
  localparam logic [VW-1:0] V_LAST_ACT = VW'(V_ACTIVE - 1);

  tft_state_e    state_q, state_d;
  logic          sof_seen_q, sof_seen_d;
  logic          resync_q, resync_d;
  logic          disp_q, disp_d;
  logic          de_q, de_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  rgb888_t       rgb_q, rgb_d;
  logic          fd_q, fd_d;
  logic          uf_q, uf_d;

  logic [HW-1:0] hcnt_s;
  logic [VW-1:0] vcnt_s;
  logic          active_s, hsync_s, vsync_s, frame_end_s;
  logic          running_s, frame_start_s, last_active_s, run_active_s;
  logic          sof_early_s, uf_set_s, sof_seen_n_s, resync_n_s, pix_ready_s;

  tft_timing_cnt #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk_i       (CLK),
    .rst_i       (RST),
    .run_i       (running_s),
    .hcnt_o      (hcnt_s),
    .vcnt_o      (vcnt_s),
    .active_o    (active_s),
    .hsync_o     (hsync_s),
    .vsync_o     (vsync_s),
    .frame_end_o (frame_end_s)
  );

  // Control decode, next state and next registered panel outputs.
  always_comb begin
    running_s     = (state_q != ST_IDLE);
    frame_start_s = (hcnt_s == '0) && (vcnt_s == '0);
    last_active_s = (hcnt_s == H_LAST_ACT) && (vcnt_s == V_LAST_ACT);
    run_active_s  = (state_q == ST_RUN) && active_s;
    // A SOF anywhere but the first pixel means the source and raster disagree.
    sof_early_s   = run_active_s && PIX_VALID && PIX_SOF && !frame_start_s;
    uf_set_s      = (run_active_s && !PIX_VALID) || sof_early_s;
    sof_seen_n_s  = sof_seen_q || (PIX_VALID && PIX_SOF);
    resync_n_s    = resync_q || sof_early_s;
    pix_ready_s   = 1'b0;
    state_d       = state_q;

    case (state_q)
      ST_IDLE: begin
        if (EN) state_d = ST_SYNC;
        else    state_d = ST_IDLE;
      end
      ST_SYNC: begin
        // The SOF pixel is left waiting on the bus so it becomes pixel 0.
        pix_ready_s = !sof_seen_q && !(PIX_VALID && PIX_SOF);
        if (frame_end_s) begin
          if (!EN)               state_d = ST_IDLE;
          else if (sof_seen_n_s) state_d = ST_RUN;
          else                   state_d = ST_SYNC;
        end else begin
          state_d = ST_SYNC;
        end
      end
      ST_RUN: begin
        pix_ready_s = active_s;
        if (frame_end_s) begin
          if (!EN)             state_d = ST_IDLE;
          else if (resync_n_s) state_d = ST_SYNC;
          else                 state_d = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if ((state_q == ST_SYNC) && (state_d == ST_SYNC)) sof_seen_d = sof_seen_n_s;
    else                                              sof_seen_d = 1'b0;
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) resync_d = resync_n_s;
    else                                            resync_d = 1'b0;

    disp_d  = running_s;
    de_d    = run_active_s;
    hsync_d = !(running_s && hsync_s);
    vsync_d = !(running_s && vsync_s);
    fd_d    = (state_q == ST_RUN) && last_active_s;
    if (run_active_s && PIX_VALID) rgb_d = PIX_DATA;
    else                           rgb_d = RGB_BLACK;
    if (uf_set_s)           uf_d = 1'b1;
    else if (UNDERFLOW_CLR) uf_d = 1'b0;
    else                    uf_d = uf_q;
  end

  // FSM state and registered panel/status outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sof_seen_q <= 1'b0;
      resync_q   <= 1'b0;
      disp_q     <= 1'b0;
      de_q       <= 1'b0;
      hsync_q    <= 1'b1;
      vsync_q    <= 1'b1;
      rgb_q      <= RGB_BLACK;
      fd_q       <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      sof_seen_q <= sof_seen_d;
      resync_q   <= resync_d;
      disp_q     <= disp_d;
      de_q       <= de_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      rgb_q      <= rgb_d;
      fd_q       <= fd_d;
      uf_q       <= uf_d;
    end
  end

  assign TFT_PCLK   = CLK;
  assign PIX_READY  = pix_ready_s;
  assign TFT_DISP   = disp_q;
  assign TFT_DE     = de_q;
  assign TFT_HSYNC  = hsync_q;
  assign TFT_VSYNC  = vsync_q;
  assign TFT_RGB    = rgb_q;
  assign FRAME_DONE = fd_q;
  assign UNDERFLOW  = uf_q;

endmodule

// File: tb/tb_tft_lcd_tx.sv
// Directed bench for tft_lcd_tx on a tiny 8x6 raster (4 active pixels x 3 lines).
module tb_tft_lcd_tx;

  logic        CLK = 1'b0;
  logic        RST, EN, PIX_VALID, PIX_SOF, UNDERFLOW_CLR;
  logic [23:0] PIX_DATA;
  logic        PIX_READY, TFT_PCLK, TFT_DISP, TFT_HSYNC, TFT_VSYNC, TFT_DE;
  logic [23:0] TFT_RGB;
  logic        FRAME_DONE, UNDERFLOW;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   idx      = 0;
  int   sof_pos  = 0;
  logic uf_exp   = 1'b0;

  tft_lcd_tx #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN),
    .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY), .PIX_SOF(PIX_SOF), .PIX_DATA(PIX_DATA),
    .TFT_PCLK(TFT_PCLK), .TFT_DISP(TFT_DISP), .TFT_HSYNC(TFT_HSYNC), .TFT_VSYNC(TFT_VSYNC),
    .TFT_DE(TFT_DE), .TFT_RGB(TFT_RGB),
    .FRAME_DONE(FRAME_DONE), .UNDERFLOW(UNDERFLOW), .UNDERFLOW_CLR(UNDERFLOW_CLR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_quiet(input string tag, input logic uf);
    chk({tag, "_disp"},  32'(TFT_DISP),   32'(0));
    chk({tag, "_de"},    32'(TFT_DE),     32'(0));
    chk({tag, "_hsync"}, 32'(TFT_HSYNC),  32'(1));
    chk({tag, "_vsync"}, 32'(TFT_VSYNC),  32'(1));
    chk({tag, "_rgb"},   32'(TFT_RGB),    32'(0));
    chk({tag, "_ready"}, 32'(PIX_READY),  32'(0));
    chk({tag, "_fd"},    32'(FRAME_DONE), 32'(0));
    chk({tag, "_uf"},    32'(UNDERFLOW),  32'(uf));
  endtask

  // Runs ncyc cycles of one 48-cycle frame starting at the raster origin.
  // run: frame is displayed (RUN) rather than a SYNC frame; drop: pixel index
  // presented with VALID=0; clr_at: cycle with UNDERFLOW_CLR; en_mode: 1 drops
  // EN from cycle 2, 2 drops EN on cycles 2..29 only.
  task automatic frame(input bit run, input int drop, input int clr_at,
                       input int en_mode, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      int h, v, k;
      bit act, take, set;
      h   = c % 8;
      v   = c / 8;
      k   = v * 4 + h;
      act = (h < 4) && (v < 3);
      EN            = !(en_mode != 0 && c >= 2 && (en_mode == 1 || c < 30));
      PIX_VALID     = !(act && k == drop);
      PIX_SOF       = (idx == sof_pos);
      PIX_DATA      = 24'(idx + 1);
      UNDERFLOW_CLR = (c == clr_at);
      #1;
      chk("ready", 32'(PIX_READY), 32'(run && act));
      take = PIX_READY;
      set  = run && act && (!PIX_VALID || (PIX_SOF && k != 0));
      tick();
      if (take) idx = (idx + 1) % 12;
      if (set) uf_exp = 1'b1;
      else if (c == clr_at) uf_exp = 1'b0;
      chk("disp",       32'(TFT_DISP),   32'(1));
      chk("de",         32'(TFT_DE),     32'(run && act));
      chk("hsync",      32'(TFT_HSYNC),  32'(!(h == 5 || h == 6)));
      chk("vsync",      32'(TFT_VSYNC),  32'(v != 4));
      chk("rgb",        32'(TFT_RGB),    (run && act && k != drop) ? 32'(k + 1) : 32'(0));
      chk("frame_done", 32'(FRAME_DONE), 32'(run && c == 19));
      chk("underflow",  32'(UNDERFLOW),  32'(uf_exp));
    end
    UNDERFLOW_CLR = 1'b0;
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; PIX_VALID = 1'b0; PIX_SOF = 1'b0;
    PIX_DATA = 24'h000000; UNDERFLOW_CLR = 1'b0;
    repeat (3) tick();
    chk_quiet("reset", 1'b0);

    RST = 1'b0;
    tick(); tick();
    chk_quiet("idle", 1'b0);

    // Enter SYNC with nothing offered: pixels would be accepted and discarded.
    EN = 1'b1; PIX_VALID = 1'b0;
    tick();
    chk("sync_ready", 32'(PIX_READY), 32'(1));

    frame(1'b0, -1, -1, 0, 48);   // SYNC frame, SOF pixel waits
    frame(1'b1, -1, -1, 0, 48);   // first displayed frame
    frame(1'b1, -1, -1, 0, 48);
    frame(1'b1,  5, -1, 0, 48);   // pixel 5 missing -> underflow
    frame(1'b1, -1, 20, 0, 48);   // clear underflow
    sof_pos = 6;
    frame(1'b1, -1, -1, 0, 48);   // misplaced SOF -> underflow, resync
    sof_pos = 0;
    frame(1'b0, -1, -1, 0, 48);   // back in SYNC
    frame(1'b1, -1, 40, 2, 48);   // EN glitch mid-frame, stays in RUN
    frame(1'b1,  5,  9, 0, 48);   // set and clear together: set wins
    frame(1'b1, -1, -1, 1, 48);   // EN dropped at pixel 2 -> IDLE at end

    chk("off_ready", 32'(PIX_READY), 32'(0));
    tick();
    chk_quiet("off", 1'b1);

    // Restart, then reset in the middle of a displayed line.
    EN = 1'b1; PIX_VALID = 1'b0;
    tick();
    chk("resync_ready", 32'(PIX_READY), 32'(1));
    frame(1'b0, -1, -1, 0, 48);
    frame(1'b1, -1, -1, 0, 11);
    RST = 1'b1;
    #1;
    chk_quiet("midreset", 1'b0);
    uf_exp = 1'b0;
    idx    = 0;
    tick(); tick();
    RST = 1'b0; PIX_VALID = 1'b0;
    tick();
    chk("rearm_ready", 32'(PIX_READY), 32'(1));
    frame(1'b0, -1, -1, 0, 48);
    frame(1'b1, -1, -1, 0, 48);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
